// File: rtl/dma_arb_pkg.sv
// Shared state type and helper functions for the DMA bus arbiter and its round-robin picker.
package dma_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_SACK,
        GRANT,
        RELEASE,
        GAP
    } arb_state_t;

    localparam int MAX_REQ = 4;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

    // Scan upward from last+1, wrapping at nreq; result is {valid, idx}.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                           input logic [1:0]         last,
                                           input int                 nreq);
        logic [2:0] res;
        int         cand;
        res = '0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            cand = (int'(last) + i) % nreq;
            if (i <= nreq && !res[2] && req[cand[1:0]]) begin
                res = {1'b1, cand[1:0]};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dma_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request after 'last', wrapping at NREQ.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [MAX_REQ-1:0] req_pad;

    always_comb begin
        req_pad            = '0;
        req_pad[NREQ-1:0]  = req;
        {valid, idx}       = rr_pick(req_pad, last, NREQ);
    end

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the CPU bus between the VM1 CPU and NREQ DMA masters using the DMR/SACK handshake,
// with a SACK timeout, a per-burst hold limit and a guaranteed CPU window between bursts.
module dma_bus_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int SACK_TIMEOUT = 64,
    parameter int MAX_HOLD     = 256,
    parameter int CPU_GAP      = 4
) (
    input  logic            clk_sys,
    input  logic            reset_n,
    input  logic            ce,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [NREQ-1:0] yield,
    output logic            cpu_dmr,
    input  logic            cpu_sack,
    output logic            dma_active,
    output logic            timeout_err,
    output logic [1:0]      last_master
);

    localparam int CNT_MAX = (SACK_TIMEOUT > MAX_HOLD)
                           ? ((SACK_TIMEOUT > CPU_GAP) ? SACK_TIMEOUT : CPU_GAP)
                           : ((MAX_HOLD > CPU_GAP) ? MAX_HOLD : CPU_GAP);
    localparam int CW = $clog2(CNT_MAX) + 1;

    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(SACK_TIMEOUT - 1);
    localparam logic [CW-1:0] HOLD_LAST    = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] HOLD_SAT     = CW'(MAX_HOLD);
    localparam logic [CW-1:0] GAP_LAST     = CW'(CPU_GAP - 1);
    localparam logic [1:0]    LAST_RESET   = 2'(NREQ - 1);

    arb_state_t         state;
    logic [CW-1:0]      cnt;
    logic [1:0]         winner;
    logic               pick_valid;
    logic [1:0]         pick_idx;
    logic [MAX_REQ-1:0] req_pad;

    always_comb begin
        req_pad           = '0;
        req_pad[NREQ-1:0] = req;
    end

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req   (req),
        .last  (last_master),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // A withdrawn request wins over a same-tick SACK so the bus is never granted to an idle master.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            winner      <= '0;
            gnt         <= '0;
            yield       <= '0;
            cpu_dmr     <= 1'b0;
            dma_active  <= 1'b0;
            timeout_err <= 1'b0;
            last_master <= LAST_RESET;
        end else if (ce) begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        cpu_dmr <= 1'b1;
                        winner  <= pick_idx;
                        cnt     <= '0;
                        state   <= WAIT_SACK;
                    end
                end
                WAIT_SACK: begin
                    cnt <= cnt + CW'(1);
                    if (!req_pad[winner]) begin
                        cpu_dmr <= 1'b0;
                        state   <= RELEASE;
                    end else if (cpu_sack) begin
                        gnt         <= NREQ'(onehot(winner));
                        dma_active  <= 1'b1;
                        last_master <= winner;
                        cnt         <= '0;
                        state       <= GRANT;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cpu_dmr     <= 1'b0;
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        state       <= GAP;
                    end
                end
                GRANT: begin
                    if (!req_pad[last_master]) begin
                        gnt        <= '0;
                        yield      <= '0;
                        dma_active <= 1'b0;
                        cpu_dmr    <= 1'b0;
                        state      <= RELEASE;
                    end else begin
                        if (cnt != HOLD_SAT) begin
                            cnt <= cnt + CW'(1);
                        end
                        if (cnt >= HOLD_LAST) begin
                            yield <= NREQ'(onehot(last_master));
                        end
                    end
                end
                RELEASE: begin
                    if (!cpu_sack) begin
                        cnt   <= '0;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (cnt >= GAP_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Self-checking bench for dma_bus_arbiter: directed scenarios plus randomized traffic
// compared every tick against a phase-level behavioural model of the bus handover.
module tb_dma_bus_arbiter;

    localparam int NREQ         = 2;
    localparam int SACK_TIMEOUT = 64;
    localparam int MAX_HOLD     = 256;
    localparam int CPU_GAP      = 4;
    localparam int OW           = 2 * NREQ + 5;

    localparam int PH_IDLE = 0;
    localparam int PH_ASK  = 1;
    localparam int PH_OWN  = 2;
    localparam int PH_REL  = 3;
    localparam int PH_GAP  = 4;

    localparam logic [OW-1:0] RESET_VEC = {NREQ'(0), NREQ'(0), 1'b0, 1'b0, 1'b0, 2'(NREQ - 1)};
    localparam logic [OW-1:0] STALL_VEC = {NREQ'(1), NREQ'(0), 1'b1, 1'b0, 1'b1, 2'd0};

    logic            clk_sys  = 1'b0;
    logic            reset_n  = 1'b0;
    logic            ce       = 1'b0;
    logic [NREQ-1:0] req      = '0;
    logic            cpu_sack = 1'b0;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] yield;
    logic            cpu_dmr;
    logic            dma_active;
    logic            timeout_err;
    logic [1:0]      last_master;
    logic [OW-1:0]   obs;

    int n_checks = 0;
    int n_fail   = 0;

    int   m_phase  = PH_IDLE;
    int   m_winner = 0;
    int   m_last   = NREQ - 1;
    int   m_wait   = 0;
    int   m_hold   = 0;
    int   m_gap    = 0;
    logic m_terr   = 1'b0;

    always #5 clk_sys = ~clk_sys;

    assign obs = {gnt, yield, cpu_dmr, timeout_err, dma_active, last_master};

    dma_bus_arbiter #(
        .NREQ         (NREQ),
        .SACK_TIMEOUT (SACK_TIMEOUT),
        .MAX_HOLD     (MAX_HOLD),
        .CPU_GAP      (CPU_GAP)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ce          (ce),
        .req         (req),
        .gnt         (gnt),
        .yield       (yield),
        .cpu_dmr     (cpu_dmr),
        .cpu_sack    (cpu_sack),
        .dma_active  (dma_active),
        .timeout_err (timeout_err),
        .last_master (last_master)
    );

    function automatic int model_pick(input logic [NREQ-1:0] r, input int last);
        int found;
        int c;
        found = -1;
        for (int i = 1; i <= NREQ; i++) begin
            c = (last + i) % NREQ;
            if (found < 0 && ((r >> c) & NREQ'(1)) != '0) found = c;
        end
        return found;
    endfunction

    function automatic logic [OW-1:0] model_out();
        logic [NREQ-1:0] g;
        logic [NREQ-1:0] y;
        g = (m_phase == PH_OWN) ? (NREQ'(1) << m_last) : '0;
        y = (m_phase == PH_OWN && m_hold >= MAX_HOLD) ? g : '0;
        return {g, y, (m_phase == PH_ASK || m_phase == PH_OWN), m_terr, (g != '0), 2'(m_last)};
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE; m_winner = 0; m_last = NREQ - 1;
        m_wait = 0; m_hold = 0; m_gap = 0; m_terr = 1'b0;
    endtask

    task automatic model_step(input logic [NREQ-1:0] r, input logic s);
        m_terr = 1'b0;
        case (m_phase)
            PH_IDLE: if (r != '0) begin
                m_winner = model_pick(r, m_last); m_wait = 0; m_phase = PH_ASK;
            end
            PH_ASK: begin
                m_wait++;
                if (((r >> m_winner) & NREQ'(1)) == '0) m_phase = PH_REL;
                else if (s) begin m_last = m_winner; m_hold = 0; m_phase = PH_OWN; end
                else if (m_wait == SACK_TIMEOUT) begin m_terr = 1'b1; m_gap = 0; m_phase = PH_GAP; end
            end
            PH_OWN: begin
                if (((r >> m_last) & NREQ'(1)) == '0) m_phase = PH_REL;
                else m_hold++;
            end
            PH_REL: if (!s) begin m_gap = 0; m_phase = PH_GAP; end
            PH_GAP: begin
                m_gap++;
                if (m_gap == CPU_GAP) m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
    endtask

    task automatic tick();
        @(posedge clk_sys);
        if (!reset_n) model_reset();
        else if (ce) model_step(req, cpu_sack);
        #1;
    endtask

    task automatic settle();
        req = '0; cpu_sack = 1'b0; ce = 1'b1;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce = 1'b0; req = '0; cpu_sack = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("[TB] FAIL reset_values: got %b expected %b", obs, RESET_VEC);
        end
        reset_n = 1'b1; ce = 1'b1;
        tick();
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("[TB] FAIL idle_no_req: got %b expected %b", obs, RESET_VEC);
        end
    endtask

    task automatic test_single_transfer();
        int first_dmr;
        req = NREQ'(1); cpu_sack = 1'b0;
        tick();
        n_checks++;
        if ({cpu_dmr, gnt} !== {1'b1, NREQ'(0)}) begin
            n_fail++; $display("[TB] FAIL dmr_raise: got %b expected %b", {cpu_dmr, gnt}, {1'b1, NREQ'(0)});
        end
        tick(); tick();
        cpu_sack = 1'b1;
        tick();
        n_checks++;
        if ({gnt, dma_active, last_master} !== {NREQ'(1), 1'b1, 2'd0}) begin
            n_fail++; $display("[TB] FAIL grant_after_sack: got %b expected %b",
                               {gnt, dma_active, last_master}, {NREQ'(1), 1'b1, 2'd0});
        end
        cpu_sack = 1'b0;
        tick(); tick();
        n_checks++;
        if ({gnt, cpu_dmr} !== {NREQ'(1), 1'b1}) begin
            n_fail++; $display("[TB] FAIL grant_stable_sack_low: got %b expected %b", {gnt, cpu_dmr}, {NREQ'(1), 1'b1});
        end
        cpu_sack = 1'b1; req = '0;
        tick();
        n_checks++;
        if ({gnt, yield, cpu_dmr, dma_active} !== '0) begin
            n_fail++; $display("[TB] FAIL release_on_req_drop: got %b expected 0", {gnt, yield, cpu_dmr, dma_active});
        end
        req = NREQ'(1);
        tick(); tick();
        n_checks++;
        if (cpu_dmr !== 1'b0) begin
            n_fail++; $display("[TB] FAIL release_holds_while_sack: got %b expected 0", cpu_dmr);
        end
        cpu_sack = 1'b0; first_dmr = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (first_dmr < 0 && cpu_dmr) first_dmr = k;
        end
        n_checks++;
        if (first_dmr != CPU_GAP + 2) begin
            n_fail++; $display("[TB] FAIL gap_length: got %0d expected %0d", first_dmr, CPU_GAP + 2);
        end
        settle();
    endtask

    task automatic test_round_robin();
        int grants, exp_idx, idx, held, low;
        logic [NREQ-1:0] prev_gnt;
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        req = '1; cpu_sack = 1'b0;
        grants = 0; exp_idx = 0; held = 0; low = 0; prev_gnt = '0;
        for (int t = 0; t < 600 && grants < 6; t++) begin
            tick();
            if (prev_gnt == '0 && gnt != '0) begin
                idx = -1;
                for (int j = 0; j < NREQ; j++) if (gnt[j]) idx = j;
                n_checks++;
                if (idx != exp_idx || !$onehot(gnt)) begin
                    n_fail++; $display("[TB] FAIL rr_order: got gnt %b expected master %0d", gnt, exp_idx);
                end
                if (grants > 0) begin
                    n_checks++;
                    if (low < CPU_GAP) begin
                        n_fail++; $display("[TB] FAIL rr_cpu_gap: got %0d cpu ticks expected at least %0d", low, CPU_GAP);
                    end
                end
                exp_idx = (exp_idx + 1) % NREQ; grants++; low = 0;
            end
            if (!cpu_dmr) low++;
            prev_gnt = gnt;
            cpu_sack = cpu_dmr;
            if (gnt != '0) begin
                held++;
                if (held >= 3) req = req & ~gnt;
            end else begin
                held = 0; req = '1;
            end
        end
        n_checks++;
        if (grants != 6) begin
            n_fail++; $display("[TB] FAIL rr_grant_count: got %0d expected 6", grants);
        end
        settle();
    endtask

    task automatic test_sack_timeout();
        int terr_at, pulses, fall_at, rise_at;
        bit any_gnt;
        terr_at = -1; pulses = 0; fall_at = -1; rise_at = -1; any_gnt = 1'b0;
        req = NREQ'(1); cpu_sack = 1'b0;
        for (int k = 0; k <= 75; k++) begin
            tick();
            if (timeout_err) begin pulses++; if (terr_at < 0) terr_at = k; end
            if (gnt != '0) any_gnt = 1'b1;
            if (k > 0 && fall_at < 0 && !cpu_dmr) fall_at = k;
            if (fall_at >= 0 && rise_at < 0 && cpu_dmr) rise_at = k;
        end
        n_checks++;
        if (terr_at != SACK_TIMEOUT || pulses != 1) begin
            n_fail++; $display("[TB] FAIL timeout_pulse: got tick %0d count %0d expected tick %0d count 1", terr_at, pulses, SACK_TIMEOUT);
        end
        n_checks++;
        if (fall_at != SACK_TIMEOUT) begin
            n_fail++; $display("[TB] FAIL timeout_dmr_fall: got %0d expected %0d", fall_at, SACK_TIMEOUT);
        end
        n_checks++;
        if (rise_at != SACK_TIMEOUT + CPU_GAP + 1) begin
            n_fail++; $display("[TB] FAIL timeout_next_dmr: got %0d expected %0d", rise_at, SACK_TIMEOUT + CPU_GAP + 1);
        end
        n_checks++;
        if (any_gnt) begin
            n_fail++; $display("[TB] FAIL timeout_no_gnt: got 1 expected 0");
        end
        settle();
    endtask

    task automatic test_max_hold();
        int first_y, y_ticks, bad;
        req = NREQ'(1); cpu_sack = 1'b0;
        tick();
        cpu_sack = 1'b1;
        tick();
        n_checks++;
        if (gnt !== NREQ'(1)) begin
            n_fail++; $display("[TB] FAIL hold_grant: got %b expected %b", gnt, NREQ'(1));
        end
        first_y = -1; y_ticks = 0; bad = 0;
        for (int h = 1; h <= 300; h++) begin
            tick();
            if (gnt !== NREQ'(1)) bad++;
            if (yield[NREQ-1:1] != '0) bad++;
            if (yield[0]) begin y_ticks++; if (first_y < 0) first_y = h; end
        end
        n_checks++;
        if (first_y != MAX_HOLD) begin
            n_fail++; $display("[TB] FAIL yield_rise: got %0d expected %0d", first_y, MAX_HOLD);
        end
        n_checks++;
        if (y_ticks != 300 - MAX_HOLD + 1 || bad != 0) begin
            n_fail++; $display("[TB] FAIL yield_hold: got %0d ticks %0d glitches expected %0d ticks 0 glitches",
                               y_ticks, bad, 300 - MAX_HOLD + 1);
        end
        req = '0;
        tick();
        n_checks++;
        if ({gnt, yield} !== '0) begin
            n_fail++; $display("[TB] FAIL yield_clears_with_gnt: got %b expected 0", {gnt, yield});
        end
        settle();
    endtask

    task automatic test_cancel();
        int first_dmr;
        bit any_terr, early;
        any_terr = 1'b0; early = 1'b0; first_dmr = -1;
        req = NREQ'(1); cpu_sack = 1'b0;
        tick(); tick();
        req = '0; cpu_sack = 1'b1;
        tick();
        n_checks++;
        if ({cpu_dmr, timeout_err, gnt} !== '0) begin
            n_fail++; $display("[TB] FAIL cancel_drops_dmr: got %b expected 0", {cpu_dmr, timeout_err, gnt});
        end
        req = NREQ'(1);
        for (int k = 0; k < 10; k++) begin
            tick();
            if (cpu_dmr || gnt != '0) early = 1'b1;
            if (timeout_err) any_terr = 1'b1;
        end
        n_checks++;
        if (early) begin
            n_fail++; $display("[TB] FAIL release_waits_sack: got early dmr/gnt expected none");
        end
        cpu_sack = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (timeout_err) any_terr = 1'b1;
            if (first_dmr < 0 && cpu_dmr) first_dmr = k;
        end
        n_checks++;
        if (first_dmr != CPU_GAP + 2) begin
            n_fail++; $display("[TB] FAIL cancel_gap: got %0d expected %0d", first_dmr, CPU_GAP + 2);
        end
        n_checks++;
        if (any_terr) begin
            n_fail++; $display("[TB] FAIL cancel_no_timeout: got 1 expected 0");
        end
        settle();
    endtask

    task automatic test_reset_mid_grant();
        int stall_bad;
        req = NREQ'(1); cpu_sack = 1'b0;
        tick();
        cpu_sack = 1'b1;
        tick();
        n_checks++;
        if (obs !== STALL_VEC) begin
            n_fail++; $display("[TB] FAIL mid_grant_setup: got %b expected %b", obs, STALL_VEC);
        end
        ce = 1'b0; req = '0; cpu_sack = 1'b0; stall_bad = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (obs !== STALL_VEC) stall_bad++;
        end
        n_checks++;
        if (stall_bad != 0) begin
            n_fail++; $display("[TB] FAIL ce_low_stall: got %0d changed ticks expected 0", stall_bad);
        end
        req = NREQ'(1); cpu_sack = 1'b1; reset_n = 1'b0;
        tick();
        n_checks++;
        if (obs !== RESET_VEC) begin
            n_fail++; $display("[TB] FAIL reset_mid_grant: got %b expected %b", obs, RESET_VEC);
        end
        reset_n = 1'b1;
        settle();
    endtask

    task automatic test_random();
        int deaf;
        logic [OW-1:0] exp_vec;
        deaf = 0;
        for (int t = 0; t < 4000; t++) begin
            tick();
            exp_vec = model_out();
            n_checks++;
            if (obs !== exp_vec) begin
                n_fail++; $display("[TB] FAIL random_t%0d: got %b expected %b", t, obs, exp_vec);
            end
            ce      = ($urandom_range(3) != 0);
            reset_n = ($urandom_range(999) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i])     req[i] = ($urandom_range(7) == 0);
                else if (gnt[i]) req[i] = ($urandom_range(15) != 0);
                else             req[i] = ($urandom_range(63) != 0);
            end
            if (deaf > 0) begin
                deaf--; cpu_sack = 1'b0;
            end else if ($urandom_range(299) == 0) begin
                deaf = 120; cpu_sack = 1'b0;
            end else if (cpu_dmr && !cpu_sack) begin
                cpu_sack = ($urandom_range(3) == 0);
            end else if (!cpu_dmr && cpu_sack) begin
                cpu_sack = ($urandom_range(1) != 0);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        $display("[TB] dma_bus_arbiter bench start");
        test_reset();
        test_single_transfer();
        test_round_robin();
        test_sack_timeout();
        test_max_hold();
        test_cancel();
        test_reset_mid_grant();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
